button_conditioner: RTL and testbench

Conditions the raw push-button inputs of the timer/stopwatch top level before they reach the control FSM. Each channel has:
- a 2-FF synchronizer;
- a counter-based debouncer;
- press/release edge pulses;
- optional hold-to-repeat, so the inc_min/inc_sec buttons auto-increment while held.

It sits between the board pins and the timer/stopwatch core. All downstream logic sees clean, single-cycle, clock-synchronous events.

---
 rtl/button_pkg.sv | 11 +
 rtl/debounce_channel.sv | 78 +++++++
 rtl/button_conditioner.sv | 31 +++
 tb/tb_button_conditioner.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// button_pkg: shared channel count, button indices, default repeat mask and repeat FSM states.
package button_pkg;
    localparam int N_BTN       = 5;
    localparam int BTN_START   = 0;
    localparam int BTN_STOP    = 1;
    localparam int BTN_SOFTRST = 2;
    localparam int BTN_INC_MIN = 3;
    localparam int BTN_INC_SEC = 4;
    localparam logic [N_BTN-1:0] REPEAT_MASK = N_BTN'((1 << BTN_INC_MIN) | (1 << BTN_INC_SEC));
    typedef enum logic [1:0] {REL, DLY, RPT} rpt_state_t;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button channel with synchronizer, counter debouncer, edge pulses and hold-to-repeat.
module debounce_channel
    import button_pkg::*;
#(
    parameter int STABLE_CYCLES        = 5_000_000,
    parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 20_000_000,
    parameter bit REPEAT_EN            = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);
    localparam int CW   = $clog2(STABLE_CYCLES);
    localparam int RMAX = REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RW   = RMAX > 1 ? $clog2(RMAX) : 1;
    logic [1:0] sync_ff;
    logic sync, lvl, rise, fall, rep_hit, cnt_done;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    rpt_state_t state, state_nxt;
    assign sync     = sync_ff[1];
    assign cnt_done = cnt == CW'(STABLE_CYCLES - 1);
    // lvl runs one cycle ahead of btn_level so the pulses line up with the visible level change
    assign rise = lvl & ~btn_level;
    assign fall = ~lvl & btn_level;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ff     <= '0;
            lvl         <= 1'b0;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            state       <= REL;
            rcnt        <= '0;
        end else begin
            sync_ff     <= {sync_ff[0], raw};
            cnt         <= (sync == lvl || cnt_done) ? '0 : cnt + CW'(1);
            lvl         <= (sync != lvl && cnt_done) ? ~lvl : lvl;
            btn_level   <= lvl;
            btn_press   <= rise | rep_hit;
            btn_release <= fall;
            state       <= state_nxt;
            rcnt        <= rcnt_nxt;
        end
    end
    // release wins over a repeat falling in the same cycle
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        rep_hit   = 1'b0;
        if (!REPEAT_EN || fall) begin
            state_nxt = REL;
            rcnt_nxt  = '0;
        end else begin
            case (state)
                REL: begin
                    state_nxt = rise ? DLY : REL;
                    rcnt_nxt  = '0;
                end
                DLY: begin
                    rep_hit   = rcnt == RW'(REPEAT_DELAY_CYCLES - 1);
                    state_nxt = rep_hit ? RPT : DLY;
                    rcnt_nxt  = rep_hit ? '0 : rcnt + RW'(1);
                end
                RPT: begin
                    rep_hit  = rcnt == RW'(REPEAT_PERIOD_CYCLES - 1);
                    rcnt_nxt = rep_hit ? '0 : rcnt + RW'(1);
                end
                default: state_nxt = REL;
            endcase
        end
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel conditioning of raw push buttons into clean levels and press/release pulses.
module button_conditioner #(
    parameter int N_BTN                   = button_pkg::N_BTN,
    parameter int STABLE_CYCLES           = 5_000_000,
    parameter int REPEAT_DELAY_CYCLES     = 50_000_000,
    parameter int REPEAT_PERIOD_CYCLES    = 20_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(button_pkg::REPEAT_MASK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES       (STABLE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES),
            .REPEAT_EN           (REPEAT_MASK[i])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .raw        (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus checked every cycle against a window/age model of the button rules.
module tb_button_conditioner;
    localparam int S = 4;
    localparam int D = 10;
    localparam int P = 4;
    localparam logic [4:0] M = 5'b11000;
    logic clk, rst;
    logic [4:0] btn_raw, btn_level, btn_press, btn_release;
    int vec, errs;
    int n_press [5];
    int n_rel [5];
    logic [S+1:0] h [5];
    int age [5];
    logic [4:0] lint, el, ep, er, pl, rw;
    logic rs, flip;
    int p3, r3, p1, r1;

    button_conditioner #(
        .N_BTN(5), .STABLE_CYCLES(S), .REPEAT_DELAY_CYCLES(D),
        .REPEAT_PERIOD_CYCLES(P), .REPEAT_MASK(M)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: level flips once the last S synchronized samples all disagree with it;
    // repeats follow from how long the visible level has been high.
    initial begin
        for (int c = 0; c < 5; c++) begin
            n_press[c] = 0;
            n_rel[c] = 0;
        end
        forever begin
            @(posedge clk);
            rs = rst;
            rw = btn_raw;
            #1;
            if (!rs) begin
                for (int c = 0; c < 5; c++) begin
                    h[c] = '0;
                    age[c] = 0;
                end
                lint = '0; el = '0; ep = '0; er = '0;
            end else begin
                pl = el;
                el = lint;
                for (int c = 0; c < 5; c++) begin
                    h[c] = {h[c][S:0], rw[c]};
                    flip = 1'b1;
                    for (int j = 2; j <= S + 1; j++) if (h[c][j] == lint[c]) flip = 1'b0;
                    if (flip) lint[c] = ~lint[c];
                    age[c] = (el[c] && !pl[c]) ? 0 : age[c] + 1;
                    ep[c] = el[c] && (!pl[c] || (M[c] && age[c] >= D && (age[c] - D) % P == 0));
                    er[c] = !el[c] && pl[c];
                end
            end
            chk("level", btn_level, el);
            chk("press", btn_press, ep);
            chk("release", btn_release, er);
            for (int c = 0; c < 5; c++) begin
                n_press[c] += int'(btn_press[c]);
                n_rel[c] += int'(btn_release[c]);
            end
        end
    end

    initial begin
        vec = 0;
        errs = 0;
        rst = 1'b0;
        btn_raw = 5'b11111;
        repeat (3) @(negedge clk);
        chk("rst_level", btn_level, 5'b00000);
        chk("rst_press", btn_press, 5'b00000);
        rst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("t1_level", btn_level, 5'b11111);
        chk("t1_press", btn_press, 5'b11111);
        @(posedge clk);
        #1;
        chk("t1_press_once", btn_press, 5'b00000);
        @(negedge clk);
        btn_raw = 5'b00000;
        repeat (12) @(negedge clk);
        chk("t1_released", btn_level, 5'b00000);

        // bounce on channel 0, then steady high
        for (int k = 0; k < 4; k++) begin
            btn_raw[0] = (k % 2 == 0);
            @(negedge clk);
        end
        btn_raw[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t2_no_early", btn_press, 5'b00000);
        @(posedge clk);
        #1;
        chk("t2_press", btn_press, 5'b00001);
        repeat (5) @(negedge clk);
        btn_raw[0] = 1'b0;
        repeat (10) @(negedge clk);

        // clean press/release on channel 1
        p1 = n_press[1];
        r1 = n_rel[1];
        btn_raw[1] = 1'b1;
        repeat (30) @(negedge clk);
        btn_raw[1] = 1'b0;
        repeat (10) @(negedge clk);
        chk("t3_press_cnt", 5'(n_press[1] - p1), 5'd1);
        chk("t3_rel_cnt", 5'(n_rel[1] - r1), 5'd1);

        // hold-to-repeat on channel 3, release lands where a repeat would fall
        p3 = n_press[3];
        r3 = n_rel[3];
        btn_raw[3] = 1'b1;
        repeat (42) @(negedge clk);
        btn_raw[3] = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_press_cnt", 5'(n_press[3] - p3), 5'd9);
        chk("t4_rel_cnt", 5'(n_rel[3] - r3), 5'd1);

        // simultaneous presses, then reset in the middle of channel 4 repeating
        btn_raw = 5'b10001;
        repeat (7) @(posedge clk);
        #1;
        chk("t5_press", btn_press, 5'b10001);
        repeat (12) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rst_level", btn_level, 5'b00000);
        chk("t6_rst_press", btn_press, 5'b00000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("t6_fresh_press", btn_press, 5'b10001);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_first_repeat", btn_press, 5'b10000);
        @(negedge clk);
        btn_raw = 5'b00000;
        repeat (12) @(negedge clk);
        chk("t6_released", btn_level, 5'b00000);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
